// File: rtl/countdown_pkg.sv
//============================================================================
// Module  : countdown_pkg
// Brief   : Shared state type and hex seven-segment patterns for countdown_mod.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Active-low gfedcba patterns, entry 0 in the least significant slot.
  localparam logic [15:0][6:0] c_SEG7_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
//============================================================================
// Module  : seg7_decoder
// Brief   : Hex digit to active-low seven-segment (gfedcba) pattern.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module seg7_decoder
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = c_SEG7_HEX[digit];

endmodule

`default_nettype wire

// File: rtl/countdown_mod.sv
//============================================================================
// Module  : countdown_mod
// Brief   : Modulo-N down counter with one-shot/wrap modes, pause and preload.
//           Optional macro COUNTDOWN_SEG7_EN adds a seven-segment output.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module countdown_mod
  import countdown_pkg::*;
#(
  parameter int MODULUS = 7,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             wrap,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             tc,
  output logic             done
`ifdef COUNTDOWN_SEG7_EN
  ,
  output logic [6:0]       seg
`endif
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_next;
  logic             r_done;
  logic             w_done_next;
  logic [WIDTH-1:0] w_load_sat;

  assign w_load_sat = (load_value > c_MAX) ? c_MAX : load_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_value <= c_MAX;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_value <= w_value_next;
      r_done  <= w_done_next;
    end
  end

  // Pause is tested before zero so a held count can never wrap or complete.
  always_comb begin
    w_state_next = r_state;
    w_value_next = r_value;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_en) begin
          w_value_next = w_load_sat;
        end else if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (pause) begin
          w_state_next = HOLD;
        end else if (r_value != '0) begin
          w_value_next = r_value - WIDTH'(1);
        end else begin
          w_value_next = c_MAX;
          if (!wrap) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!pause) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    tc   = (r_state == RUN) && (r_value == '0);
  end

  assign value = r_value;
  assign done  = r_done;

`ifdef COUNTDOWN_SEG7_EN
  logic [3:0] w_digit;
  assign w_digit = 4'(r_value);

  seg7_decoder u_seg7 (
    .digit (w_digit),
    .seg   (seg)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_countdown_mod.sv
//============================================================================
// Module  : tb_countdown_mod
// Brief   : Self-checking bench for countdown_mod (directed + randomized).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_countdown_mod;

  localparam int MOD = 7;
  localparam int W   = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         wrap = 1'b0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] value;
  logic         busy;
  logic         tc;
  logic         done;
`ifdef COUNTDOWN_SEG7_EN
  logic [6:0]   seg;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count value plus two flags, advanced once per clock edge.
  int m_v    = MOD - 1;
  bit m_busy = 0;
  bit m_held = 0;
  bit m_done = 0;

  countdown_mod #(.MODULUS(MOD), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .wrap       (wrap),
    .load_en    (load_en),
    .load_value (load_value),
    .value      (value),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
`ifdef COUNTDOWN_SEG7_EN
    ,
    .seg        (seg)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_v = MOD - 1; m_busy = 0; m_held = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (load_en) m_v = (int'(load_value) > MOD - 1) ? MOD - 1 : int'(load_value);
        else if (start) m_busy = 1;
      end else if (m_held) begin
        if (!pause) m_held = 0;
      end else if (pause) begin
        m_held = 1;
      end else if (m_v != 0) begin
        m_v = m_v - 1;
      end else begin
        m_v = MOD - 1;
        if (!wrap) begin m_busy = 0; m_done = 1; end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    n_tests++;
    if (value !== 3'd6) begin n_fail++; $display("FAIL reset_value got=%0d exp=6", value); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got=%b exp=0", tc); end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] ev;
    wrap = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < MOD; i++) begin
      ev = 3'(6 - i);
      n_tests++;
      if (value !== ev || tc !== (i == 6) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_step%0d got v=%0d tc=%b busy=%b done=%b exp v=%0d tc=%b busy=1 done=0",
                 i, value, tc, busy, done, ev, (i == 6));
      end
      tick();
    end
    n_tests++;
    if (value !== 3'd6 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_end got v=%0d busy=%b done=%b exp v=6 busy=0 done=1", value, busy, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL oneshot_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] ev;
    wrap = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3 * MOD; i++) begin
      ev = 3'(6 - (i % MOD));
      n_tests++;
      if (value !== ev || tc !== ((i % MOD) == 6) || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_step%0d got v=%0d tc=%b done=%b busy=%b exp v=%0d tc=%b done=0 busy=1",
                 i, value, tc, done, busy, ev, ((i % MOD) == 6));
      end
      tick();
    end
    wrap = 1'b0;
    do_reset();
  endtask

  task automatic test_load();
    load_en = 1'b1; load_value = 3'd7; tick();
    n_tests++;
    if (value !== 3'd6 || busy !== 1'b0) begin
      n_fail++; $display("FAIL load_sat got v=%0d busy=%b exp v=6 busy=0", value, busy);
    end
    load_value = 3'd3; start = 1'b1; tick();
    load_en = 1'b0; start = 1'b0; tick();
    n_tests++;
    if (value !== 3'd3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL load_wins got v=%0d busy=%b exp v=3 busy=0", value, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (value !== 3'(3 - i) || busy !== 1'b1) begin
        n_fail++; $display("FAIL load_count%0d got v=%0d busy=%b exp v=%0d busy=1", i, value, busy, 3 - i);
      end
      tick();
    end
    n_tests++;
    if (value !== 3'd6 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL load_done got v=%0d busy=%b done=%b exp v=6 busy=0 done=1", value, busy, done);
    end
  endtask

  task automatic test_pause();
    wrap = 1'b0; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (value !== 3'd4 || busy !== 1'b1 || tc !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold%0d got v=%0d busy=%b tc=%b exp v=4 busy=1 tc=0", i, value, busy, tc);
      end
    end
    pause = 1'b0; tick();
    n_tests++;
    if (value !== 3'd4) begin n_fail++; $display("FAIL pause_release got=%0d exp=4", value); end
    tick();
    n_tests++;
    if (value !== 3'd3) begin n_fail++; $display("FAIL pause_resume got=%0d exp=3", value); end
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (value !== 3'd2) begin n_fail++; $display("FAIL abort_setup got=%0d exp=2", value); end
    do_reset();
    n_tests++;
    if (value !== 3'd6 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort got v=%0d busy=%b done=%b exp v=6 busy=0 done=0", value, busy, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", done); end
`ifdef COUNTDOWN_SEG7_EN
    n_tests++;
    if (seg !== 7'b0000010) begin n_fail++; $display("FAIL seg_six got=%b exp=0000010", seg); end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] ev;
    bit etc;
    do_reset();
    m_v = MOD - 1; m_busy = 0; m_held = 0; m_done = 0;
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(99) < 2);
      start      = ($urandom_range(99) < 30);
      load_en    = ($urandom_range(99) < 10);
      pause      = ($urandom_range(99) < 20);
      wrap       = $urandom_range(1);
      load_value = 3'($urandom_range(7));
      model_edge();
      tick();
      ev  = 3'(m_v);
      etc = m_busy && !m_held && (m_v == 0);
      n_tests++;
      if (value !== ev || busy !== m_busy || tc !== etc || done !== m_done) begin
        n_fail++;
        $display("FAIL random_cyc%0d got v=%0d busy=%b tc=%b done=%b exp v=%0d busy=%b tc=%b done=%b",
                 i, value, busy, tc, done, ev, m_busy, etc, m_done);
      end
    end
    reset = 1'b0; start = 1'b0; load_en = 1'b0; pause = 1'b0; wrap = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_wrap();
    test_load();
    test_pause();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
